// File: rtl/minhash_sorter_pkg.sv
// Shared widths, slot types and FSM states for the minhash sorter.
package minhash_sorter_pkg;

  localparam int SORTER_EXTENDER_INDICES_COUNT = 4;
  localparam int HASHER_SORTER_SIGNATURE       = 32;
  localparam int SORTER_INDICE_LEN             = 8;
  localparam int SORTER_K                      = SORTER_EXTENDER_INDICES_COUNT;

  typedef struct packed {
    logic [HASHER_SORTER_SIGNATURE-1:0] signature;
    logic [SORTER_INDICE_LEN-1:0]       index;
  } signature_index_pack;

  typedef struct packed {
    logic                valid;
    signature_index_pack entry;
  } slot_t;

  typedef enum logic {S_COLLECT, S_FLUSH} sorter_state_e;

endpackage

// File: rtl/minhash_sorter_cell.sv
// One slot of the insertion-sorted array: holds, takes the new item, or takes the slot above.
// MINHASH_SORTER_DEDUP_EN enables the equal-signature match output used for dedup.
module minhash_sorter_cell
  import minhash_sorter_pkg::*;
#(
  parameter int SIG_W = HASHER_SORTER_SIGNATURE,
  parameter int IDX_W = SORTER_INDICE_LEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             insert_en,
  input  logic [SIG_W-1:0] new_sig,
  input  logic [IDX_W-1:0] new_idx,
  input  logic             up_valid,
  input  logic [SIG_W-1:0] up_sig,
  input  logic [IDX_W-1:0] up_idx,
  input  logic             up_new_is_less,
  output logic             valid,
  output logic [SIG_W-1:0] sig,
  output logic [IDX_W-1:0] idx,
  output logic             new_is_less,
  output logic             sig_match
);

  logic             valid_d, valid_q;
  logic [SIG_W-1:0] sig_d, sig_q;
  logic [IDX_W-1:0] idx_d, idx_q;

  // An empty slot behaves as +infinity, so the new item always lands in it.
  assign new_is_less = !valid_q || (new_sig < sig_q);

`ifdef MINHASH_SORTER_DEDUP_EN
  assign sig_match = valid_q && (new_sig == sig_q);
`else
  assign sig_match = 1'b0;
`endif

  assign valid = valid_q;
  assign sig   = sig_q;
  assign idx   = idx_q;

  always_comb begin
    valid_d = valid_q;
    sig_d   = sig_q;
    idx_d   = idx_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (insert_en) begin
      if (up_new_is_less) begin
        valid_d = up_valid;
        sig_d   = up_sig;
        idx_d   = up_idx;
      end else if (new_is_less) begin
        valid_d = 1'b1;
        sig_d   = new_sig;
        idx_d   = new_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= 1'b0;
    else     valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    sig_q <= sig_d;
    idx_q <= idx_d;
  end

endmodule

// File: rtl/minhash_sorter.sv
// Keeps the K smallest signatures of a fragment and streams their indices in ascending order.
// MINHASH_SORTER_DEDUP_EN drops items whose signature already sits in a valid slot.
module minhash_sorter
  import minhash_sorter_pkg::*;
#(
  parameter int K     = SORTER_K,
  parameter int SIG_W = HASHER_SORTER_SIGNATURE,
  parameter int IDX_W = SORTER_INDICE_LEN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SIG_W+IDX_W-1:0] in_data,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IDX_W-1:0]       out_index,
  output logic [SIG_W-1:0]       out_signature,
  output logic                   out_last
);

  localparam int CNT_W = $clog2(K + 1);
  localparam int RD_W  = (K > 1) ? $clog2(K) : 1;

  sorter_state_e    state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [RD_W-1:0]  rd_d, rd_q;

  logic [SIG_W-1:0] new_sig;
  logic [IDX_W-1:0] new_idx;
  logic             accept, drop, insert_en, flush_done, dup_hit;

  logic             slot_valid [K];
  logic [SIG_W-1:0] slot_sig   [K];
  logic [IDX_W-1:0] slot_idx   [K];
  logic             nil        [K];
  logic             match      [K];
  logic             up_valid   [K];
  logic [SIG_W-1:0] up_sig     [K];
  logic [IDX_W-1:0] up_idx     [K];
  logic             up_nil     [K];

  assign new_sig   = in_data[SIG_W+IDX_W-1:IDX_W];
  assign new_idx   = in_data[IDX_W-1:0];
  assign drop      = dup_hit;
  assign insert_en = accept && !drop;

  for (genvar g = 0; g < K; g++) begin : g_cell
    if (g == 0) begin : g_head
      assign up_valid[g] = 1'b0;
      assign up_sig[g]   = '0;
      assign up_idx[g]   = '0;
      assign up_nil[g]   = 1'b0;
    end else begin : g_body
      assign up_valid[g] = slot_valid[g-1];
      assign up_sig[g]   = slot_sig[g-1];
      assign up_idx[g]   = slot_idx[g-1];
      assign up_nil[g]   = nil[g-1];
    end

    minhash_sorter_cell #(.SIG_W(SIG_W), .IDX_W(IDX_W)) u_cell (
      .clk           (clk),
      .rst           (rst),
      .clear         (flush_done),
      .insert_en     (insert_en),
      .new_sig       (new_sig),
      .new_idx       (new_idx),
      .up_valid      (up_valid[g]),
      .up_sig        (up_sig[g]),
      .up_idx        (up_idx[g]),
      .up_new_is_less(up_nil[g]),
      .valid         (slot_valid[g]),
      .sig           (slot_sig[g]),
      .idx           (slot_idx[g]),
      .new_is_less   (nil[g]),
      .sig_match     (match[g])
    );
  end

  always_comb begin
    dup_hit = 1'b0;
    for (int i = 0; i < K; i++) dup_hit = dup_hit | match[i];
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rd_d          = rd_q;
    in_ready      = 1'b0;
    out_valid     = 1'b0;
    out_last      = 1'b0;
    out_index     = '0;
    out_signature = '0;
    accept        = 1'b0;
    flush_done    = 1'b0;
    case (state_q)
      S_COLLECT: begin
        in_ready = 1'b1;
        accept   = in_valid;
        // Below K every accepted item is stored; at K the tail is evicted instead.
        if (accept && !drop && (cnt_q != CNT_W'(K))) cnt_d = cnt_q + CNT_W'(1);
        if (accept && in_last) begin
          state_d = S_FLUSH;
          rd_d    = '0;
        end
      end
      S_FLUSH: begin
        out_valid     = 1'b1;
        out_index     = slot_idx[rd_q];
        out_signature = slot_sig[rd_q];
        out_last      = (CNT_W'(rd_q) == (cnt_q - CNT_W'(1)));
        if (out_ready) begin
          if (out_last) begin
            flush_done = 1'b1;
            state_d    = S_COLLECT;
            cnt_d      = '0;
            rd_d       = '0;
          end else begin
            rd_d = rd_q + RD_W'(1);
          end
        end
      end
      default: state_d = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_COLLECT;
      cnt_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
    end
  end

endmodule

// File: tb/tb_minhash_sorter.sv
// Scoreboard bench for minhash_sorter: a reference selection model feeds an expected queue.
`timescale 1ns/1ps
module tb_minhash_sorter;
  import minhash_sorter_pkg::*;

  localparam int K     = SORTER_K;
  localparam int SIG_W = HASHER_SORTER_SIGNATURE;
  localparam int IDX_W = SORTER_INDICE_LEN;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic [SIG_W+IDX_W-1:0] in_data;
  logic                   in_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [IDX_W-1:0]       out_index;
  logic [SIG_W-1:0]       out_signature;
  logic                   out_last;

  always #5 clk = ~clk;

  minhash_sorter dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_index    (out_index),
    .out_signature(out_signature),
    .out_last     (out_last)
  );

  typedef struct {
    logic [SIG_W-1:0] sig;
    logic [IDX_W-1:0] idx;
    logic             last;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every output handshake against the scoreboard head.
  logic             prev_stall = 1'b0;
  logic [IDX_W-1:0] prev_idx   = '0;
  logic [SIG_W-1:0] prev_sig   = '0;
  exp_t             head;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_out_valid", 64'(out_valid), 64'(1));
        check("stall_out_index", 64'(out_index), 64'(prev_idx));
        check("stall_out_signature", 64'(out_signature), 64'(prev_sig));
      end
      if (out_valid) begin
        check("in_ready_during_flush", 64'(in_ready), 64'(0));
        if (out_ready) begin
          if (sb.size() == 0) begin
            check("unexpected_output_index", 64'(out_index), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            head = sb.pop_front();
            check("out_index", 64'(out_index), 64'(head.idx));
            check("out_signature", 64'(out_signature), 64'(head.sig));
            check("out_last", 64'(out_last), 64'(head.last));
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_idx   = out_index;
      prev_sig   = out_signature;
    end
  end

  // Reference: the K smallest signatures, earliest arrival first among equals.
  task automatic model_fragment(input logic [SIG_W-1:0] sigs[$], input logic [IDX_W-1:0] idxs[$]);
    exp_t all[$];
    exp_t e;
    int   n;
    int   best;
    bit   dup;
    for (int i = 0; i < sigs.size(); i++) begin
      dup = 1'b0;
`ifdef MINHASH_SORTER_DEDUP_EN
      foreach (all[j]) if (all[j].sig == sigs[i]) dup = 1'b1;
`endif
      if (!dup) begin
        e.sig = sigs[i]; e.idx = idxs[i]; e.last = 1'b0;
        all.push_back(e);
      end
    end
    n = (all.size() < K) ? all.size() : K;
    for (int r = 0; r < n; r++) begin
      best = 0;
      for (int j = 1; j < all.size(); j++) if (all[j].sig < all[best].sig) best = j;
      e = all[best];
      e.last = (r == n - 1);
      sb.push_back(e);
      all.delete(best);
    end
  endtask

  task automatic send_item(input logic [SIG_W-1:0] s, input logic [IDX_W-1:0] ix, input logic last);
    int b = 0;
    in_valid = 1'b1;
    in_data  = {s, ix};
    in_last  = last;
    while (!in_ready && b < 300) begin
      @(posedge clk); #1;
      b++;
    end
    if (!in_ready) check("accept_timeout", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
  endtask

  task automatic send_fragment(input logic [SIG_W-1:0] sigs[$], input logic [IDX_W-1:0] idxs[$],
                               input bit hold);
    model_fragment(sigs, idxs);
    for (int i = 0; i < sigs.size(); i++) send_item(sigs[i], idxs[i], i == sigs.size() - 1);
    if (!hold) begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    int b = 0;
    while (sb.size() != 0 && b < 300) begin
      @(posedge clk); #1;
      b++;
    end
    check({name, "_drained"}, 64'(sb.size()), 64'(0));
    check({name, "_in_ready_after"}, 64'(in_ready), 64'(1));
    check({name, "_out_valid_after"}, 64'(out_valid), 64'(0));
  endtask

  task automatic wait_out_valid(input string name);
    int b = 0;
    while (!out_valid && b < 100) begin
      @(posedge clk); #1;
      b++;
    end
    check({name, "_out_valid_seen"}, 64'(out_valid), 64'(1));
  endtask

  logic [SIG_W-1:0] sq[$];
  logic [IDX_W-1:0] iq[$];
  bit               rand_done;
  int               len;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_in_ready", 64'(in_ready), 64'(1));
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_out_last", 64'(out_last), 64'(0));
    check("reset_out_index", 64'(out_index), 64'(0));
    check("reset_out_signature", 64'(out_signature), 64'(0));

    sq = '{32'd9, 32'd3, 32'd7, 32'd1, 32'd5}; iq = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4};
    send_fragment(sq, iq, 1'b0);
    drain("five_items");

    sq = '{32'd8, 32'd4}; iq = '{8'd10, 8'd11};
    send_fragment(sq, iq, 1'b0);
    drain("two_items");

    sq = '{32'd5, 32'd5, 32'd2}; iq = '{8'd0, 8'd1, 8'd2};
    send_fragment(sq, iq, 1'b0);
    drain("ties");

    // Backpressure: one entry out, then three stalled cycles.
    out_ready = 1'b0;
    sq = '{32'd40, 32'd30, 32'd20, 32'd10, 32'd50, 32'd60}; iq = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10};
    send_fragment(sq, iq, 1'b0);
    wait_out_valid("backpressure");
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    drain("backpressure");

    // Back-to-back fragments with in_valid held across the boundary.
    sq = '{32'd100, 32'd7, 32'd300, 32'd2, 32'd50}; iq = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    send_fragment(sq, iq, 1'b1);
    sq = '{32'd900, 32'd800}; iq = '{8'd20, 8'd21};
    send_fragment(sq, iq, 1'b0);
    drain("back_to_back");

    // Reset during FLUSH after one entry.
    out_ready = 1'b0;
    sq = '{32'd3, 32'd1, 32'd2}; iq = '{8'd30, 8'd31, 8'd32};
    send_fragment(sq, iq, 1'b0);
    wait_out_valid("mid_flush_reset");
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    check("post_reset_out_valid", 64'(out_valid), 64'(0));
    check("post_reset_in_ready", 64'(in_ready), 64'(1));
    out_ready = 1'b1;
    sq = '{32'd6, 32'd2}; iq = '{8'd40, 8'd41};
    send_fragment(sq, iq, 1'b0);
    drain("after_reset");

    // Randomized fragments with random output backpressure.
    rand_done = 1'b0;
    fork
      begin
        for (int f = 0; f < 40; f++) begin
          sq.delete(); iq.delete();
          len = $urandom_range(1, 9);
          for (int i = 0; i < len; i++) begin
            sq.push_back(($urandom_range(0, 1) != 0) ? SIG_W'($urandom_range(0, 12)) : SIG_W'($urandom));
            iq.push_back(IDX_W'($urandom));
          end
          send_fragment(sq, iq, (f % 3) == 0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        drain("random");
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join

    check("final_scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
